// File: rtl/pe_pkg.sv
// Shared types and constants for the 3x3 PE array and its output-side psum collector.
// Holds the default widths plus a saturating narrow-down helper for accumulator values.
package pe_pkg;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 20;
   localparam int LANES  = 3;

   typedef logic signed [DATA_W-1:0] psum_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   typedef struct packed {
      logic  sat;
      psum_t data;
   } sat_t;

   localparam acc_t SAT_MAX = acc_t'((1 << (DATA_W-1)) - 1);
   localparam acc_t SAT_MIN = acc_t'(-(1 << (DATA_W-1)));

   function automatic sat_t sat_to_data(input acc_t value);
      sat_t res;
      if (value > SAT_MAX) begin
         res.sat  = 1'b1;
         res.data = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (value < SAT_MIN) begin
         res.sat  = 1'b1;
         res.data = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         res.sat  = 1'b0;
         res.data = value[DATA_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/psum_fifo.sv
// First-word-fall-through FIFO of parameterised width and power-of-two depth.
// The head reads as zero while empty so downstream sees clean data after reset.
module psum_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/psum_collector.sv
// Accumulates PE-array row lanes across channel passes per output column, saturates
// finished columns and queues them for the ofmap writer under valid/ready.
module psum_collector #(
   parameter  int DATA_W     = pe_pkg::DATA_W,
   parameter  int ACC_W      = pe_pkg::ACC_W,
   parameter  int LANES      = pe_pkg::LANES,
   parameter  int COLS       = 3,
   parameter  int NUM_CH     = 4,
   parameter  int FIFO_DEPTH = 4,
   localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_psum,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES-1:0]        out_sat,
   output logic [COL_W-1:0]        out_col,
   output logic                    tile_done
);

   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = COL_W + LANES + LANES*DATA_W;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W-1)));

   logic [COL_W-1:0]        col_cnt;
   logic [CH_W-1:0]         ch_cnt;
   logic [0:0]              state;
   logic signed [ACC_W-1:0] acc [COLS][LANES];
   logic signed [ACC_W-1:0] sum [LANES];
   logic [LANES*DATA_W-1:0] sat_data;
   logic [LANES-1:0]        sat_flag;

   logic                    accept;
   logic                    first_ch;
   logic                    last_col;
   logic                    last_ch;
   logic                    last_beat;
   logic                    push;
   logic                    pop;
   logic [ENTRY_W-1:0]      head;
   logic [CNT_W-1:0]        count;
   logic                    full;
   logic                    empty;

   assign in_ready  = !rst && (count < CNT_W'(FIFO_DEPTH));
   assign accept    = in_valid && in_ready;
   assign last_col  = (col_cnt == COL_W'(COLS - 1));
   assign last_ch   = (ch_cnt == CH_W'(NUM_CH - 1));
   assign last_beat = last_col && last_ch;
   // IDLE always coincides with ch 0; either term selects the overwrite path.
   assign first_ch  = (state == ST_IDLE) || (ch_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt   <= '0;
         ch_cnt    <= '0;
         state     <= ST_IDLE;
         tile_done <= 1'b0;
      end else begin
         tile_done <= accept && last_beat;
         if (accept) begin
            if (last_col) begin
               col_cnt <= '0;
               ch_cnt  <= last_ch ? '0 : ch_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
            state <= last_beat ? ST_IDLE : ST_ACCUM;
         end
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      sat_data = '0;
      sat_flag = '0;
      for (int l = 0; l < LANES; l++) begin
         sum[l] = (first_ch ? '0 : acc[col_cnt][l])
                + {{(ACC_W-DATA_W){in_psum[l*DATA_W + DATA_W-1]}}, in_psum[l*DATA_W +: DATA_W]};
         if (sum[l] > SAT_MAX) begin
            sat_data[l*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
            sat_flag[l]                  = 1'b1;
         end else if (sum[l] < SAT_MIN) begin
            sat_data[l*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
            sat_flag[l]                  = 1'b1;
         end else begin
            sat_data[l*DATA_W +: DATA_W] = sum[l][DATA_W-1:0];
         end
      end
   end

   // The final-channel result goes straight to the FIFO, so that pass leaves acc untouched.
   always_ff @(posedge clk) begin
      if (accept && !last_ch) begin
         for (int l = 0; l < LANES; l++) begin
            acc[col_cnt][l] <= sum[l];
         end
      end
   end

   assign push = accept && last_ch && !full;
   assign pop  = out_valid && out_ready;

   psum_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({col_cnt, sat_flag, sat_data}),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign out_valid = !empty;
   assign out_col   = head[ENTRY_W-1 -: COL_W];
   assign out_sat   = head[LANES*DATA_W +: LANES];
   assign out_data  = head[LANES*DATA_W-1:0];

endmodule

// File: tb/tb_psum_collector.sv
// Directed self-checking bench for psum_collector with default parameters.
// Each task drives one scenario and compares against hand-computed expectations.
module tb_psum_collector;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [47:0] in_psum   = '0;
   logic        in_ready;
   logic        out_valid;
   logic [47:0] out_data;
   logic [2:0]  out_sat;
   logic [1:0]  out_col;
   logic        tile_done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   logic [1:0]  cap_col  [$];
   logic [2:0]  cap_sat  [$];
   logic [47:0] cap_data [$];

   psum_collector dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_psum   (in_psum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_col   (out_col),
      .tile_done (tile_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         cap_col.push_back(out_col);
         cap_sat.push_back(out_sat);
         cap_data.push_back(out_data);
      end
      if (!rst && tile_done) done_cnt++;
   end

   function automatic logic [47:0] pk(input logic [15:0] v);
      return {v, v, v};
   endfunction

   task automatic clear_capture();
      cap_col.delete();
      cap_sat.delete();
      cap_data.delete();
      done_cnt = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [47:0] p);
      int n;
      in_valid = 1'b1;
      in_psum  = p;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_tile(input logic [15:0] v);
      for (int i = 0; i < 12; i++) send_beat(pk(v));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 48'h0 ||
          out_sat !== 3'b000 || out_col !== 2'd0 || tile_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: in_ready=%b out_valid=%b data=%h sat=%b col=%0d done=%b, required all 0",
                  in_ready, out_valid, out_data, out_sat, out_col, tile_done);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_counting();
      out_ready = 1'b1;
      clear_capture();
      for (int i = 0; i < 12; i++) begin
         send_beat(pk(16'd1));
         if (i == 8) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL count_no_early_valid: out_valid=%b required 0", out_valid);
            end
         end
         if (i == 9) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_col !== 2'd0 || out_data !== pk(16'd4)) begin
               n_fail++;
               $display("FAIL count_latency: valid=%b col=%0d data=%h required 1/0/%h",
                        out_valid, out_col, out_data, pk(16'd4));
            end
         end
         if (i == 10) begin
            n_checks++;
            if (done_cnt != 0 || tile_done !== 1'b0) begin
               n_fail++;
               $display("FAIL count_done_early: done_cnt=%0d tile_done=%b required 0/0", done_cnt, tile_done);
            end
         end
         if (i == 11) begin
            n_checks++;
            if (tile_done !== 1'b1) begin
               n_fail++;
               $display("FAIL count_done_pulse: tile_done=%b required 1", tile_done);
            end
         end
      end
      idle(4);
      n_checks++;
      if (done_cnt != 1 || tile_done !== 1'b0) begin
         n_fail++;
         $display("FAIL count_done_once: done_cnt=%0d tile_done=%b required 1/0", done_cnt, tile_done);
      end
      n_checks++;
      if (cap_data.size() != 3) begin
         n_fail++;
         $display("FAIL count_n_results: got %0d required 3", cap_data.size());
      end
      for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
         n_checks++;
         if (cap_col[i] !== 2'(i) || cap_data[i] !== pk(16'd4) || cap_sat[i] !== 3'b000) begin
            n_fail++;
            $display("FAIL count_result%0d: col=%0d data=%h sat=%b required col=%0d data=%h sat=000",
                     i, cap_col[i], cap_data[i], cap_sat[i], i, pk(16'd4));
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] l2;
      out_ready = 1'b1;
      clear_capture();
      for (int i = 0; i < 12; i++) begin
         l2 = (i % 2 == 0) ? 16'd5 : 16'hFFFD;
         send_beat({l2, 16'h8000, 16'h7FFF});
      end
      idle(4);
      n_checks++;
      if (cap_data.size() != 3) begin
         n_fail++;
         $display("FAIL sat_n_results: got %0d required 3", cap_data.size());
      end
      for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
         n_checks++;
         if (cap_col[i] !== 2'(i) || cap_data[i] !== {16'h0004, 16'h8000, 16'h7FFF} || cap_sat[i] !== 3'b011) begin
            n_fail++;
            $display("FAIL sat_result%0d: col=%0d data=%h sat=%b required col=%0d data=000480007fff sat=011",
                     i, cap_col[i], cap_data[i], cap_sat[i], i);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [1:0]  exp_col [6];
      logic [47:0] exp_val [6];
      exp_col = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      exp_val = '{pk(16'd4), pk(16'd4), pk(16'd4), pk(16'd8), pk(16'd8), pk(16'd8)};
      out_ready = 1'b0;
      clear_capture();
      send_tile(16'd1);
      for (int i = 0; i < 10; i++) send_beat(pk(16'd2));
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_col !== 2'd0) begin
         n_fail++;
         $display("FAIL bp_full: in_ready=%b out_valid=%b col=%0d required 0/1/0", in_ready, out_valid, out_col);
      end
      in_valid = 1'b1;
      in_psum  = pk(16'd2);
      idle(3);
      n_checks++;
      if (in_ready !== 1'b0 || out_data !== pk(16'd4) || cap_data.size() != 0) begin
         n_fail++;
         $display("FAIL bp_stall: in_ready=%b data=%h popped=%0d required 0/%h/0",
                  in_ready, out_data, cap_data.size(), pk(16'd4));
      end
      out_ready = 1'b1;
      send_beat(pk(16'd2));
      send_beat(pk(16'd2));
      idle(10);
      n_checks++;
      if (cap_data.size() != 6) begin
         n_fail++;
         $display("FAIL bp_n_results: got %0d required 6", cap_data.size());
      end
      for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
         n_checks++;
         if (cap_col[i] !== exp_col[i] || cap_data[i] !== exp_val[i] || cap_sat[i] !== 3'b000) begin
            n_fail++;
            $display("FAIL bp_order%0d: col=%0d data=%h sat=%b required col=%0d data=%h sat=000",
                     i, cap_col[i], cap_data[i], cap_sat[i], exp_col[i], exp_val[i]);
         end
      end
   endtask

   task automatic test_tile_isolation();
      logic [47:0] exp_val [6];
      exp_val = '{pk(16'd400), pk(16'd400), pk(16'd400), pk(16'd4), pk(16'd4), pk(16'd4)};
      out_ready = 1'b1;
      clear_capture();
      send_tile(16'd100);
      send_tile(16'd1);
      idle(4);
      n_checks++;
      if (cap_data.size() != 6 || done_cnt != 2) begin
         n_fail++;
         $display("FAIL iso_n_results: got %0d results %0d tiles required 6/2", cap_data.size(), done_cnt);
      end
      for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
         n_checks++;
         if (cap_col[i] !== 2'(i % 3) || cap_data[i] !== exp_val[i]) begin
            n_fail++;
            $display("FAIL iso_result%0d: col=%0d data=%h required col=%0d data=%h",
                     i, cap_col[i], cap_data[i], i % 3, exp_val[i]);
         end
      end
   endtask

   task automatic test_reset_mid_tile();
      out_ready = 1'b1;
      clear_capture();
      for (int i = 0; i < 7; i++) send_beat(pk(16'd5));
      rst = 1'b1;
      idle(1);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_during: out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
      end
      idle(1);
      rst = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_after: out_valid=%b required 0", out_valid);
      end
      send_tile(16'd2);
      idle(4);
      n_checks++;
      if (cap_data.size() != 3 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL rst_mid_n_results: got %0d results %0d tiles required 3/1", cap_data.size(), done_cnt);
      end
      for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
         n_checks++;
         if (cap_col[i] !== 2'(i) || cap_data[i] !== pk(16'd8)) begin
            n_fail++;
            $display("FAIL rst_mid_result%0d: col=%0d data=%h required col=%0d data=%h",
                     i, cap_col[i], cap_data[i], i, pk(16'd8));
         end
      end
   endtask

   task automatic test_collision();
      out_ready = 1'b0;
      clear_capture();
      for (int i = 0; i < 10; i++) send_beat(pk(16'd3));
      n_checks++;
      if (out_valid !== 1'b1 || out_col !== 2'd0) begin
         n_fail++;
         $display("FAIL coll_setup: out_valid=%b col=%0d required 1/0", out_valid, out_col);
      end
      out_ready = 1'b1;
      send_beat(pk(16'd3));
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_col !== 2'd1 || out_data !== pk(16'd12)) begin
         n_fail++;
         $display("FAIL coll_head: valid=%b col=%0d data=%h required 1/1/%h",
                  out_valid, out_col, out_data, pk(16'd12));
      end
      send_beat(pk(16'd3));
      out_ready = 1'b1;
      idle(6);
      n_checks++;
      if (cap_data.size() != 3 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_n_results: got %0d out_valid=%b required 3/0", cap_data.size(), out_valid);
      end
      for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
         n_checks++;
         if (cap_col[i] !== 2'(i) || cap_data[i] !== pk(16'd12)) begin
            n_fail++;
            $display("FAIL coll_order%0d: col=%0d data=%h required col=%0d data=%h",
                     i, cap_col[i], cap_data[i], i, pk(16'd12));
         end
      end
   endtask

   initial begin
      test_reset();
      test_counting();
      test_saturation();
      test_backpressure();
      test_tile_isolation();
      test_reset_mid_tile();
      test_collision();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_collector.md
# psum_collector

Output-side companion to the 3x3 PE array. It receives the array's three row lanes of partial sums, one output column per beat. It accumulates each column across NUM_CH input-channel passes and saturates finished columns to DATA_W. Finished columns are queued in a small FIFO for the ofmap writer under valid/ready.

## Interface
Parameters:
- DATA_W, 16: input psum width and output width; signed.
- ACC_W, 20: accumulator width; signed.
- LANES, 3: PE rows, i.e. parallel lanes per beat.
- COLS, 3: output columns per tile.
- NUM_CH, 4: channel passes accumulated per tile; must be at least 1.
- FIFO_DEPTH, 4: output queue entries; power of two.

Ports:
- Reset is `rst`, synchronous, active-high. Clock is `clk`.
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: beat valid.
- in_ready, out, 1: beat accepted when in_valid && in_ready.
- in_psum, in, LANES*DATA_W: lane k occupies bits [k*DATA_W +: DATA_W]; signed.
- out_valid, out, 1: FIFO head valid.
- out_ready, in, 1: consumer ready.
- out_data, out, LANES*DATA_W: saturated column result, same lane packing as in_psum.
- out_sat, out, LANES: per-lane saturation flag travelling with out_data.
- out_col, out, $clog2(COLS): column index of the head entry.
- tile_done, out, 1: one-cycle pulse when the last beat of a tile is accepted.

## Operation
- Beat order within a tile: for ch = 0..NUM_CH-1, for col = 0..COLS-1.
- Counters col_cnt and ch_cnt track position. Both advance only on an accepted beat.
  - col_cnt wraps at COLS-1 and increments ch_cnt.
  - ch_cnt wraps at NUM_CH-1, which also ends the tile.
- Accumulator bank: acc[col][lane], ACC_W each. Inputs are sign-extended to ACC_W.
  - ch_cnt==0: acc[col] <= in_psum. This is an overwrite, so no explicit clear is needed between tiles.
  - 0 < ch_cnt < NUM_CH-1: acc[col] <= acc[col] + in_psum.
  - ch_cnt==NUM_CH-1: result = acc[col] + in_psum, or just in_psum when NUM_CH==1. The result is saturated and pushed to the FIFO together with the col index. acc[col] is not written.
- Saturation per lane:
  - Result > 2^(DATA_W-1)-1 gives 0x7FFF (for DATA_W=16) and sat=1.
  - Result < -2^(DATA_W-1) gives 0x8000 and sat=1.
  - Otherwise the result is truncated to DATA_W and sat=0.
- Accumulation wraps silently at ACC_W. Callers size ACC_W >= DATA_W + clog2(NUM_CH).
- FSM states:
  - IDLE: no beat of the current tile accepted yet.
  - ACCUM: mid-tile.
  - IDLE -> ACCUM on any accepted beat, unless the tile is a single beat (COLS==1 and NUM_CH==1).
  - ACCUM -> IDLE on acceptance of the last beat of the tile. tile_done pulses in the same cycle.
- in_ready = !rst && (fifo_count < FIFO_DEPTH).
  - in_ready is registered-safe: it does not depend on out_ready in the same cycle.
  - in_ready applies to every beat, not only final-channel beats.
- FIFO: push on an accepted final-channel beat; pop on out_valid && out_ready.
  - Simultaneous push and pop is legal at any count below FIFO_DEPTH. The count is unchanged.
  - A pop at full frees a slot for the next cycle only.

## Timing
- Reset values: in_ready=0 while rst is high, then 1; out_valid=0; out_data=0; out_sat=0; out_col=0; tile_done=0.
- Reset also clears col_cnt, ch_cnt, the FIFO count and pointers, and sets state to IDLE. Accumulators need no reset.
- Latency: a final-channel beat accepted at edge t gives out_valid=1 with its data after edge t, i.e. in cycle t+1, provided the FIFO was empty.
- The FIFO is first-word-fall-through. out_data is stable while out_valid && !out_ready.
- Reset mid-tile discards partial sums and queued results. The first beat after reset is treated as ch=0, col=0.
- No combinational path from in_valid or in_psum to any output.
- tile_done is registered: high for exactly one cycle.

## Structure
- Shared package pe_pkg holds DATA_W, ACC_W, LANES, psum_t (signed DATA_W) and acc_t (signed ACC_W), plus a sat_to_data function.
- One sub-module, psum_fifo: a parameterised width/depth FWFT FIFO with push, pop, count, full and empty.
- The top level holds the counters, the FSM, the accumulator bank and the saturation logic.

## Test plan
- Counting: defaults, all lanes=1 on all 12 beats, out_ready=1. Expect 3 outputs, cols 0,1,2, each lane=4, sat=0, and one tile_done on beat 12.
- Saturation: lane0=0x7FFF and lane1=0x8000 on every beat, lane2 alternating +5/-3. Expect lane0=0x7FFF with sat[0]=1, lane1=0x8000 with sat[1]=1, lane2=4 with sat[2]=0.
- Backpressure: out_ready=0, two tiles streamed.
  - in_ready drops after the 4th result is queued, with the second tile stalled mid-tile.
  - Raising out_ready drains entries in order col 0,1,2,0, and then the remaining beats complete.
- Tile isolation: tile A all lanes=100, then tile B all lanes=1. Tile B outputs equal 4, confirming the ch=0 overwrite.
- Reset mid-tile: rst pulsed after 7 beats, then a full tile of lanes=2. Expect out_valid=0 during and after reset, then exactly 3 results of 8.
- Push/pop collision: the FIFO holds 1 entry, out_ready=1, and a final beat is accepted in the same cycle. The count stays at 1 and the output order is preserved.
